rcv_frame: RTL and testbench

//  Serial frame receiver directly downstream of the high-reset input synchronizer.

---
 rtl/rcv_pkg.sv | 11 +
 rtl/rx_bit_timer.sv | 41 ++++
 rtl/rcv_frame.sv | 97 +++++++++
 tb/tb_rcv_frame.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rcv_pkg.sv
// Shared types and defaults for the serial frame receiver.
package rcv_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, LOAD} rx_state_t;

  localparam int DEFAULT_CLKS_PER_BIT = 10;

  // Sample counter must reach DATA_BITS+1 for the largest frame (16 data bits).
  localparam int BIT_CNT_W = 5;

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-period timer: one-cycle sample strobe after a half period, then every full period.
// Strobe fires CLKS_PER_BIT/2 cycles after clear; no backpressure, runs only while enabled.
module rx_bit_timer
  import rcv_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT + 1)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 half_first,
  output logic                 sample,
  output logic [BIT_CNT_W-1:0] bit_cnt
);

  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_END = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] timer;

  assign sample = enable && (timer == (half_first ? HALF_END : FULL_END));

  // Reloading on every strobe keeps each sample exactly one bit period after the last.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      timer   <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      timer   <= '0;
      bit_cnt <= '0;
    end else if (sample) begin
      timer   <= '0;
      bit_cnt <= bit_cnt + 1'b1;
    end else if (enable) begin
      timer   <= timer + 1'b1;
    end
  end

endmodule

// File: rtl/rcv_frame.sv
// Serial frame receiver: start-edge detect, mid-bit sampling, LSB-first deserialize, stop check.
// rx_data valid CLKS_PER_BIT/2+(DATA_BITS+1)*CLKS_PER_BIT+2 cycles after start; no backpressure, unread data is overwritten (overrun).
module rcv_frame
  import rcv_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT + 1)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 serial_in,
  input  logic                 data_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 overrun_error,
  output logic                 framing_error,
  output logic                 busy
);

  localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS);

  rx_state_t              state;
  rx_state_t              state_nxt;
  logic                   prev_in;
  logic                   start;
  logic                   timing;
  logic                   sample;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [DATA_BITS-1:0]   shift_reg;
  logic [DATA_BITS:0]     shift_ext;

  assign start     = (state == IDLE) && prev_in && !serial_in;
  assign timing    = (state == START) || (state == DATA) || (state == STOP);
  assign busy      = (state != IDLE);
  assign shift_ext = {serial_in, shift_reg};

  rx_bit_timer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .CNT_W        (CNT_W)
  ) u_bit_timer (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (start),
    .enable     (timing),
    .half_first (state == START),
    .sample     (sample),
    .bit_cnt    (bit_cnt)
  );

  // bit_cnt already includes the start-bit sample, so the last data bit sees DATA_BITS.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = START;
      START:   if (sample) state_nxt = serial_in ? IDLE : DATA;
      DATA:    if (sample && (bit_cnt == LAST_DATA)) state_nxt = STOP;
      STOP:    if (sample) state_nxt = serial_in ? LOAD : IDLE;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      prev_in   <= 1'b1;
      shift_reg <= '0;
    end else begin
      state   <= state_nxt;
      prev_in <= serial_in;
      if ((state == DATA) && sample) shift_reg <= shift_ext[DATA_BITS:1];
    end
  end

  // A LOAD takes priority over a simultaneous host read of the previous byte.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rx_data       <= '0;
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (state == LOAD) begin
        rx_data       <= shift_reg;
        data_ready    <= 1'b1;
        overrun_error <= data_ready && !data_read;
      end else if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
      if (start) framing_error <= 1'b0;
      else if ((state == STOP) && sample && !serial_in) framing_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rcv_frame.sv
// Bench for rcv_frame: directed frames with literal timing checks plus randomized traffic,
// all outputs compared every cycle against a bit-offset reference model.
module tb_rcv_frame;

  localparam int D = 8;
  localparam int C = 10;
  localparam int H = C / 2;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         serial_in = 1'b1;
  logic         data_read = 1'b0;
  logic [D-1:0] rx_data;
  logic         data_ready;
  logic         overrun_error;
  logic         framing_error;
  logic         busy;

  rcv_frame #(
    .DATA_BITS    (D),
    .CLKS_PER_BIT (C)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .serial_in     (serial_in),
    .data_read     (data_read),
    .rx_data       (rx_data),
    .data_ready    (data_ready),
    .overrun_error (overrun_error),
    .framing_error (framing_error),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int t_prev = 0;
  int gap = 0;
  bit stp = 1'b1;
  logic [D-1:0] rb;
  bit manual_read = 1'b0;
  bit rnd_read = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Single driver for data_read: either the directed pulse or random host reads.
  always @(negedge clk) begin
    #1;
    data_read <= rnd_read ? ($urandom_range(0, 5) == 0) : manual_read;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: tracks the age of the current frame in cycles since the start
  // edge and picks samples at offsets H + n*C.
  bit           m_prev, m_active, m_load, m_ready, m_ovr, m_ferr;
  int           m_age;
  logic [D-1:0] m_bits, m_data;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_prev   <= 1'b1;
      m_active <= 1'b0;
      m_load   <= 1'b0;
      m_age    <= 0;
      m_bits   <= '0;
      m_data   <= '0;
      m_ready  <= 1'b0;
      m_ovr    <= 1'b0;
      m_ferr   <= 1'b0;
    end else begin : model
      int           k;
      int           idx;
      bit           act;
      bit           ld;
      logic [D-1:0] bits;
      if (m_load) begin
        m_data  <= m_bits;
        m_ready <= 1'b1;
        m_ovr   <= m_ready && !data_read;
      end else if (data_read) begin
        m_ready <= 1'b0;
        m_ovr   <= 1'b0;
      end
      act  = m_active;
      ld   = 1'b0;
      bits = m_bits;
      if (m_active) begin
        k = m_age;
        if (k == H && serial_in) begin
          act = 1'b0;
        end else if (k > H && ((k - H) % C) == 0) begin
          idx = (k - H) / C - 1;
          if (idx < D) begin
            bits[idx] = serial_in;
          end else begin
            act = 1'b0;
            ld  = serial_in;
            if (!serial_in) m_ferr <= 1'b1;
          end
        end
        m_age <= k + 1;
      end else if (!m_load && m_prev && !serial_in) begin
        act = 1'b1;
        m_age  <= 1;
        m_ferr <= 1'b0;
      end
      m_active <= act;
      m_load   <= ld;
      m_bits   <= bits;
      m_prev   <= serial_in;
    end
  end

  bit rdy_q = 1'b0, busy_q = 1'b0, ferr_q = 1'b0;
  int rdy_rise = -1, busy_rise = -1, busy_fall = -1, ferr_fall = -1;

  always @(negedge clk) begin
    chk("rx_data",       32'(rx_data),       32'(m_data));
    chk("data_ready",    32'(data_ready),    32'(m_ready));
    chk("overrun_error", 32'(overrun_error), 32'(m_ovr));
    chk("framing_error", 32'(framing_error), 32'(m_ferr));
    chk("busy",          32'(busy),          32'(m_active || m_load));
    if (data_ready && !rdy_q) rdy_rise <= cyc;
    if (busy && !busy_q) busy_rise <= cyc;
    if (!busy && busy_q) busy_fall <= cyc;
    if (!framing_error && ferr_q) ferr_fall <= cyc;
    rdy_q  <= data_ready;
    busy_q <= busy;
    ferr_q <= framing_error;
  end

  // All stimulus tasks start and end on a falling edge.
  task automatic send_frame(input logic [D-1:0] d, input logic stop, input int nbits);
    logic [D+1:0] seq;
    seq = {stop, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      serial_in = seq[i];
      if (i == 0) t0 = cyc;
      repeat (C) @(negedge clk);
    end
  endtask

  task automatic glitch(input int n);
    serial_in = 1'b0;
    t0 = cyc;
    repeat (n) @(negedge clk);
    serial_in = 1'b1;
  endtask

  task automatic idle(input int n);
    serial_in = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_read();
    manual_read = 1'b1;
    @(negedge clk);
    manual_read = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rx_data", 32'(rx_data), 32'h0);
    chk("rst_ready",   32'(data_ready), 32'h0);
    chk("rst_ovr",     32'(overrun_error), 32'h0);
    chk("rst_ferr",    32'(framing_error), 32'h0);
    chk("rst_busy",    32'(busy), 32'h0);
    #2 n_rst = 1'b1;
    idle(5);

    // Good frame 0xA5
    send_frame(8'hA5, 1'b1, D + 2);
    idle(3);
    chk("a5_busy_rise",  busy_rise, t0 + 1);
    chk("a5_ready_time", rdy_rise, t0 + 97);
    chk("a5_busy_fall",  busy_fall, t0 + 97);
    chk("a5_data",       32'(rx_data), 32'hA5);
    chk("a5_ferr",       32'(framing_error), 32'h0);
    pulse_read();
    chk("a5_read_clr",   32'(data_ready), 32'h0);

    // Short low glitch: START decides at T0+5, IDLE visible from T0+6
    glitch(3);
    idle(10);
    chk("gl_busy_rise", busy_rise, t0 + 1);
    chk("gl_busy_fall", busy_fall, t0 + H + 1);
    chk("gl_ready",     32'(data_ready), 32'h0);
    chk("gl_data",      32'(rx_data), 32'hA5);

    // Bad stop bit, then the line stays low: no new start
    send_frame(8'h3C, 1'b0, D + 2);
    chk("fe_ferr",  32'(framing_error), 32'h1);
    chk("fe_ready", 32'(data_ready), 32'h0);
    chk("fe_data",  32'(rx_data), 32'hA5);
    repeat (20) @(negedge clk);
    chk("fe_low_busy", 32'(busy), 32'h0);
    idle(5);
    send_frame(8'h66, 1'b1, D + 2);
    idle(3);
    chk("fe_clear_time", ferr_fall, t0 + 1);
    chk("fe_next_data",  32'(rx_data), 32'h66);
    pulse_read();

    // Two back-to-back frames without a read
    send_frame(8'h11, 1'b1, D + 2);
    send_frame(8'h22, 1'b1, D + 2);
    idle(3);
    chk("ov_data",  32'(rx_data), 32'h22);
    chk("ov_flag",  32'(overrun_error), 32'h1);
    chk("ov_ready", 32'(data_ready), 32'h1);
    pulse_read();
    chk("ov_rd_ready", 32'(data_ready), 32'h0);
    chk("ov_rd_flag",  32'(overrun_error), 32'h0);

    // Read coinciding with LOAD of a second frame
    send_frame(8'h77, 1'b1, D + 2);
    fork
      send_frame(8'h88, 1'b1, D + 2);
      begin
        repeat (96) @(negedge clk);
        manual_read = 1'b1;
        @(negedge clk);
        manual_read = 1'b0;
      end
    join
    idle(3);
    chk("ld_rd_ready", 32'(data_ready), 32'h1);
    chk("ld_rd_ovr",   32'(overrun_error), 32'h0);
    chk("ld_rd_data",  32'(rx_data), 32'h88);

    // Reset after data bit 3 of a frame, with unread data pending
    send_frame(8'hC3, 1'b1, 5);
    #2 n_rst = 1'b0;
    serial_in = 1'b1;
    #1;
    chk("mr_data",  32'(rx_data), 32'h0);
    chk("mr_ready", 32'(data_ready), 32'h0);
    chk("mr_ovr",   32'(overrun_error), 32'h0);
    chk("mr_ferr",  32'(framing_error), 32'h0);
    chk("mr_busy",  32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    #2 n_rst = 1'b1;
    idle(5);
    send_frame(8'h5A, 1'b1, D + 2);
    idle(3);
    chk("mr_new_data",  32'(rx_data), 32'h5A);
    chk("mr_new_ready", 32'(data_ready), 32'h1);
    chk("mr_new_ovr",   32'(overrun_error), 32'h0);
    pulse_read();

    // Random traffic: payloads, bad stops, glitches, gaps and host reads
    rnd_read = 1'b1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        glitch($urandom_range(1, H - 2));
        idle($urandom_range(1, 12));
      end else begin
        rb  = D'($urandom);
        stp = ($urandom_range(0, 6) != 0);
        t_prev = t0;
        send_frame(rb, stp, D + 2);
        gap = $urandom_range(0, 12);
        if (!stp && gap == 0) gap = 1;
        idle(gap);
      end
    end
    rnd_read = 1'b0;
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
